// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. Lookup is purely combinational; updates from the execute stage
//   commit on the rising clock edge (read-before-write for a same-cycle
//   lookup of the same entry).
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset (clears valid bits and counters)
//   flush       synchronous invalidate-all, has priority over an update
//   lkp_pc      fetch PC to look up
//   lkp_hit     valid entry with matching tag
//   lkp_taken   hit and counter MSB set
//   lkp_target  stored target on hit, else lkp_pc + 4
//   upd_en      one resolved-branch update this cycle
//   upd_pc      PC of the resolved branch
//   upd_taken   actual outcome
//   upd_target  actual taken target
// ---------------------------------------------------------------------------
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [XLEN-1:0] lkp_pc,
    output logic            lkp_hit,
    output logic            lkp_taken,
    output logic [XLEN-1:0] lkp_target,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    typedef enum logic [1:0] {
        CNT_STRONG_NT = 2'b00,
        CNT_WEAK_NT   = 2'b01,
        CNT_WEAK_T    = 2'b10,
        CNT_STRONG_T  = 2'b11
    } cnt_e;

    logic [ENTRIES-1:0] valid_q;
    cnt_e               cnt_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    // The two low PC bits carry no information for word-aligned fetch.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lkp_pc[1:0], upd_pc[1:0]};

    // ---------------- lookup (combinational) ----------------
    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;

    assign lkp_idx    = lkp_pc[IDX_W+1:2];
    assign lkp_tag    = lkp_pc[XLEN-1:IDX_W+2];
    assign lkp_hit    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign lkp_taken  = lkp_hit && cnt_q[lkp_idx][1];
    assign lkp_target = lkp_hit ? target_q[lkp_idx] : lkp_pc + XLEN'(4);

    // ---------------- update ----------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    cnt_e             cnt_d;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q[upd_idx];
        if (upd_taken) begin
            if (cnt_q[upd_idx] != CNT_STRONG_T) cnt_d = cnt_e'(cnt_q[upd_idx] + 2'd1);
        end else begin
            if (cnt_q[upd_idx] != CNT_STRONG_NT) cnt_d = cnt_e'(cnt_q[upd_idx] - 2'd1);
        end
    end

    // Valid bits and counters: reset asynchronously so the table is empty
    // the instant rst_n falls, whatever an in-flight update was doing.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values and lookup sees read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_STRONG_NT;
        end else if (flush) begin
            valid_q <= '0;
        end else if (upd_en) begin
            if (upd_hit) begin
                cnt_q[upd_idx] <= cnt_d;
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                cnt_q[upd_idx]   <= CNT_WEAK_T;
            end
        end
    end

    // NOTE: tag and target storage is deliberately left without reset; an
    // entry's contents are only observable through its valid bit, which is
    // reset. A write landing while rst_n is low only touches an invalid
    // entry, so it is harmless.
    always_ff @(posedge clk) begin
        if (!flush && upd_en && upd_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer
//   Directed vector table for the documented scenarios, hand-written reset
//   sequences, then randomized traffic compared against a behavioural model
//   that stores entries indexed by integer arithmetic on the PC.
// ---------------------------------------------------------------------------
module tb_branch_target_buffer;

    localparam int ENTRIES = 16;
    localparam int XLEN    = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [XLEN-1:0] lkp_pc;
    logic            lkp_hit;
    logic            lkp_taken;
    logic [XLEN-1:0] lkp_target;
    logic            upd_en;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;

    int checks   = 0;
    int failures = 0;

    branch_target_buffer #(.ENTRIES(ENTRIES), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .lkp_pc     (lkp_pc),
        .lkp_hit    (lkp_hit),
        .lkp_taken  (lkp_taken),
        .lkp_target (lkp_target),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit              m_valid  [ENTRIES];
    longint unsigned m_tag    [ENTRIES];
    longint unsigned m_target [ENTRIES];
    int              m_cnt    [ENTRIES];

    function automatic int m_index(input longint unsigned pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic longint unsigned m_tagof(input longint unsigned pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic model_update(input bit f, input bit en, input longint unsigned pc,
                                input bit tk, input longint unsigned tgt);
        int i;
        i = m_index(pc);
        if (f) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (en) begin
            if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
                m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                              : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
                if (tk) m_target[i] = tgt;
            end else if (tk) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = m_tagof(pc);
                m_target[i] = tgt;
                m_cnt[i]    = 2;
            end
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit              flush;
        bit              upd_en;
        logic [XLEN-1:0] upd_pc;
        bit              upd_taken;
        logic [XLEN-1:0] upd_target;
        logic [XLEN-1:0] lkp_pc;
        bit              exp_hit;
        bit              exp_taken;
        logic [XLEN-1:0] exp_target;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input bit f, input bit en, input logic [XLEN-1:0] upc, input bit tk,
                                input logic [XLEN-1:0] utg, input logic [XLEN-1:0] lpc,
                                input bit eh, input bit et, input logic [XLEN-1:0] etg);
        vec_t v;
        v.flush = f; v.upd_en = en; v.upd_pc = upc; v.upd_taken = tk; v.upd_target = utg;
        v.lkp_pc = lpc; v.exp_hit = eh; v.exp_taken = et; v.exp_target = etg;
        return v;
    endfunction

    // One clock cycle: drive at the falling edge, check the combinational
    // lookup (pre-update contents), then let the rising edge commit.
    task automatic drive(input bit f, input bit en, input logic [XLEN-1:0] upc, input bit tk,
                         input logic [XLEN-1:0] utg, input logic [XLEN-1:0] lpc);
        @(negedge clk);
        flush = f; upd_en = en; upd_pc = upc; upd_taken = tk; upd_target = utg; lkp_pc = lpc;
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; upd_en = 1'b0; upd_taken = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        lkp_pc = 32'h100;
        model_clear();

        // Reset held: outputs forced to miss, and a taken update is ignored.
        drive(1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 32'h100);
        check("rst_hit",    {31'd0, lkp_hit},   '0);
        check("rst_taken",  {31'd0, lkp_taken}, '0);
        check("rst_target", lkp_target,         32'h104);
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // Build the vector table.
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,  32'h100, 0,0,32'h104)); // empty after reset
        vecs.push_back(mk(0,1,32'h100,1,32'h200,32'h100, 0,0,32'h104)); // alloc, read-before-write
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,  32'h100, 1,1,32'h200)); // cnt 10
        vecs.push_back(mk(0,1,32'h100,0,32'h0,  32'h100, 1,1,32'h200)); // -> 01
        vecs.push_back(mk(0,1,32'h100,0,32'h0,  32'h100, 1,0,32'h200)); // -> 00
        vecs.push_back(mk(0,1,32'h100,0,32'h0,  32'h100, 1,0,32'h200)); // sat 00
        vecs.push_back(mk(0,1,32'h100,0,32'h0,  32'h100, 1,0,32'h200)); // sat 00
        vecs.push_back(mk(0,1,32'h100,1,32'h200,32'h100, 1,0,32'h200)); // -> 01
        vecs.push_back(mk(0,1,32'h100,1,32'h200,32'h100, 1,0,32'h200)); // -> 10
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,  32'h100, 1,1,32'h200));
        vecs.push_back(mk(0,1,32'h140,1,32'h300,32'h140, 0,0,32'h144)); // alias replace
        vecs.push_back(mk(0,1,32'h180,0,32'h0,  32'h100, 0,0,32'h104)); // NT miss: no alloc
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,  32'h140, 1,1,32'h300));
        vecs.push_back(mk(0,1,32'h140,1,32'h340,32'h140, 1,1,32'h300)); // -> 11, new target
        vecs.push_back(mk(0,1,32'h140,1,32'h340,32'h140, 1,1,32'h340)); // sat 11
        vecs.push_back(mk(0,1,32'h140,0,32'h999,32'h140, 1,1,32'h340)); // -> 10, target kept
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,  32'h142, 1,1,32'h340)); // low bits ignored
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,  32'hFFFF_FFFC, 0,0,32'h0)); // wrap-around
        vecs.push_back(mk(0,1,32'h104,1,32'h500,32'h104, 0,0,32'h108));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,  32'h104, 1,1,32'h500));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,  32'h140, 1,1,32'h340)); // neighbour intact
        vecs.push_back(mk(1,1,32'h108,1,32'h600,32'h140, 1,1,32'h340)); // flush wins
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,  32'h108, 0,0,32'h10C));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,  32'h140, 0,0,32'h144));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,  32'h104, 0,0,32'h108));

        foreach (vecs[n]) begin
            drive(vecs[n].flush, vecs[n].upd_en, vecs[n].upd_pc, vecs[n].upd_taken,
                  vecs[n].upd_target, vecs[n].lkp_pc);
            check($sformatf("vec%0d_hit", n),    {31'd0, lkp_hit},   {31'd0, vecs[n].exp_hit});
            check($sformatf("vec%0d_taken", n),  {31'd0, lkp_taken}, {31'd0, vecs[n].exp_taken});
            check($sformatf("vec%0d_target", n), lkp_target,         vecs[n].exp_target);
        end
        // Table ends flushed, which matches a cleared model.

        // Reset pulse between edges with the table populated.
        drive(0, 1, 32'h100, 1, 32'h200, 32'h100);
        drive(0, 0, 32'h0, 0, 32'h0, 32'h100);
        check("pre_pulse_hit", {31'd0, lkp_hit}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("pulse_hit",    {31'd0, lkp_hit}, '0);
        check("pulse_target", lkp_target,       32'h104);
        rst_n = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0, 32'h100);
        check("post_pulse_hit", {31'd0, lkp_hit}, '0);

        // Reset asserted across an edge while an update is in flight.
        drive(0, 1, 32'h104, 1, 32'h700, 32'h104);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        check("mid_upd_hit", {31'd0, lkp_hit}, '0);
        drive(0, 0, 32'h0, 0, 32'h0, 32'h104);
        check("mid_upd_hit2", {31'd0, lkp_hit}, '0);
        model_clear();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [XLEN-1:0] upc, lpc, tgt;
            bit f, en, tk;
            int li;
            bit eh;
            upc = {$urandom_range(3, 0) == 3 ? 26'h3FF_FFFF : 26'($urandom_range(3, 0)),
                   4'($urandom_range(15, 0)), 2'($urandom_range(3, 0))};
            lpc = {$urandom_range(3, 0) == 3 ? 26'h3FF_FFFF : 26'($urandom_range(3, 0)),
                   4'($urandom_range(15, 0)), 2'($urandom_range(3, 0))};
            tgt = $urandom;
            f   = ($urandom_range(63, 0) == 0);
            en  = ($urandom_range(3, 0) != 0);
            tk  = ($urandom_range(2, 0) != 0);
            drive(f, en, upc, tk, tgt, lpc);
            li = m_index(lpc);
            eh = m_valid[li] && (m_tag[li] == m_tagof(lpc));
            check("rnd_hit",    {31'd0, lkp_hit},   {31'd0, eh});
            check("rnd_taken",  {31'd0, lkp_taken}, {31'd0, eh && (m_cnt[li] >= 2)});
            check("rnd_target", lkp_target,
                  eh ? XLEN'(m_target[li]) : XLEN'((longint'(lpc) + 4) % (64'd1 << XLEN)));
            @(posedge clk);
            model_update(f, en, upc, tk, tgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped entries (power of two, >=2).
REQ-002 Parameter XLEN, default 32, address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous invalidate-all request.
REQ-007 lkp_pc  input  XLEN  fetch-stage PC to look up.
REQ-008 lkp_hit  output  1  valid entry with matching tag at lkp_pc.
REQ-009 lkp_taken  output  1  predicted taken (hit and counter MSB set).
REQ-010 lkp_target  output  XLEN  stored target of the hit entry, else lkp_pc+4.
REQ-011 upd_en  input  1  execute-stage resolved branch, one update per asserted cycle.
REQ-012 upd_pc  input  XLEN  PC of the resolved branch.
REQ-013 upd_taken  input  1  actual outcome (1 = taken).
REQ-014 upd_target  input  XLEN  actual taken target.

Function
REQ-015 Index SHALL be pc[log2(ENTRIES)+1:2]; tag SHALL be pc[XLEN-1:log2(ENTRIES)+2]; pc[1:0] ignored.
REQ-016 Each entry SHALL hold valid (1), tag, target (XLEN), 2-bit counter: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
REQ-017 Lookup SHALL be combinational, zero-cycle: lkp_hit = valid & tag match; lkp_taken = lkp_hit & counter[1]; lkp_target = hit ? target : lkp_pc+4 (mod 2^XLEN).
REQ-018 Update hit (upd_en, entry valid, tag match): counter +1 saturating at 11 if upd_taken, -1 saturating at 00 otherwise.
REQ-019 Update hit with upd_taken: target SHALL be overwritten with upd_target; with !upd_taken target SHALL be unchanged.
REQ-020 Update miss with upd_taken: entry SHALL be allocated/replaced: valid=1, tag from upd_pc, target=upd_target, counter=10.
REQ-021 Update miss with !upd_taken: no state change.
REQ-022 Updates SHALL take effect at the rising edge ending the upd_en cycle; same-cycle lookup of that index returns pre-update contents (read-before-write).
REQ-023 flush SHALL clear all valid bits at the next edge; tags, targets, counters need not change.
REQ-024 flush and upd_en in the same cycle: flush wins, the update is discarded.
REQ-025 upd_en with X-free inputs SHALL never modify any entry other than the indexed one.
REQ-026 Wrap-around: lkp_pc = 2^XLEN-4 on miss SHALL give lkp_target = 0.

Reset
REQ-027 rst_n low SHALL immediately clear all valid bits and set all counters to 00, independent of clk.
REQ-028 While rst_n low: lkp_hit=0, lkp_taken=0, lkp_target=lkp_pc+4; updates and flush ignored.
REQ-029 Release of rst_n SHALL be synchronised externally; first update may occur on the first edge after release.
REQ-030 Reset asserted mid-update SHALL leave the table fully invalid; no partial entry survives.

Verification
REQ-031 After reset, lkp_pc=0x100 -> lkp_hit=0, lkp_taken=0, lkp_target=0x104.
REQ-032 upd_en, upd_pc=0x100, taken, target=0x200; next cycle lookup 0x100 -> hit=1, taken=1, target=0x200, counter=10.
REQ-033 Four not-taken updates to 0x100 after REQ-032 -> counter 01 after first (taken=0, hit=1), saturates 00; then two taken -> 10, taken=1.
REQ-034 Alias: entry for 0x100 then taken update 0x140 (ENTRIES=16, same index) -> 0x100 misses, 0x140 hits target=upd_target; not-taken miss to 0x180 leaves 0x140 intact.
REQ-035 flush and taken upd_en same cycle -> all lookups miss next cycle, no allocation.
REQ-036 rst_n pulsed low between edges with table populated -> lkp_hit drops to 0 before next edge; hit stays 0 after release until a new allocation.
